// File: rtl/estagio_mem.sv
// estagio_mem -- memory-access stage and EX/MEM pipeline register.
//
// Captures the EX-stage ALU result and control bits. Performs a word-aligned
// load or store on an internal synchronous data RAM. Presents a registered
// MEM/WB bundle, including the branch-taken decision.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   valido_ex           EX presents a valid instruction this cycle
//   resultado, zero     ALU result (byte address for memory ops) and zero flag
//   dado_escrita        store data
//   mem_read, mem_write, reg_write, mem_to_reg, branch, reg_dest
//                       EX control bits and destination register
//   stall, flush        hold this stage / squash the incoming instruction
//   valido_wb .. erro_acesso
//                       registered MEM/WB bundle
module estagio_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valido_ex,
  input  logic [DATA_W-1:0] resultado,
  input  logic              zero,
  input  logic [DATA_W-1:0] dado_escrita,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              branch,
  input  logic [REG_W-1:0]  reg_dest,
  input  logic              stall,
  input  logic              flush,
  output logic              valido_wb,
  output logic [DATA_W-1:0] resultado_wb,
  output logic [DATA_W-1:0] dado_lido,
  output logic [REG_W-1:0]  reg_dest_wb,
  output logic              reg_write_wb,
  output logic              mem_to_reg_wb,
  output logic              desvio_tomado,
  output logic              erro_acesso
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aceita;
  logic              acessoMem;
  logic              ilegal;
  logic              escreve;
  logic [ADDR_W-1:0] endereco;

  logic              validoWb_q,     validoWb_d;
  logic [DATA_W-1:0] resultadoWb_q,  resultadoWb_d;
  logic [DATA_W-1:0] dadoLido_q,     dadoLido_d;
  logic [REG_W-1:0]  regDestWb_q,    regDestWb_d;
  logic              regWriteWb_q,   regWriteWb_d;
  logic              memToRegWb_q,   memToRegWb_d;
  logic              desvioTomado_q, desvioTomado_d;
  logic              erroAcesso_q,   erroAcesso_d;

  // Address decode and legality check. Upper address bits are dropped, so
  // accesses wrap modulo the RAM depth. A misaligned address or a combined
  // read+write is illegal and gets suppressed entirely.
  always_comb begin
    aceita    = valido_ex & ~stall & ~flush & ~reset;
    endereco  = resultado[ADDR_W+1:2];
    acessoMem = mem_read | mem_write;
    ilegal    = acessoMem & ((resultado[1:0] != 2'b00) | (mem_read & mem_write));
    escreve   = aceita & mem_write & ~ilegal;
  end

  // Next-state of the MEM/WB bundle. Hold is the default, covering stall.
  // A flush, or an unstalled cycle with no valid instruction, loads a bubble;
  // flush wins over stall. The RAM read here is registered below, so a load
  // sees the contents from before this edge's write.
  always_comb begin
    validoWb_d     = validoWb_q;
    resultadoWb_d  = resultadoWb_q;
    dadoLido_d     = dadoLido_q;
    regDestWb_d    = regDestWb_q;
    regWriteWb_d   = regWriteWb_q;
    memToRegWb_d   = memToRegWb_q;
    desvioTomado_d = desvioTomado_q;
    erroAcesso_d   = erroAcesso_q;
    if (flush || (!stall && !valido_ex)) begin
      validoWb_d     = 1'b0;
      resultadoWb_d  = '0;
      dadoLido_d     = '0;
      regDestWb_d    = '0;
      regWriteWb_d   = 1'b0;
      memToRegWb_d   = 1'b0;
      desvioTomado_d = 1'b0;
      erroAcesso_d   = 1'b0;
    end else if (!stall) begin
      validoWb_d     = 1'b1;
      resultadoWb_d  = resultado;
      dadoLido_d     = (mem_read && !ilegal) ? mem[endereco] : '0;
      regDestWb_d    = reg_dest;
      regWriteWb_d   = reg_write & ~ilegal;
      memToRegWb_d   = mem_to_reg;
      desvioTomado_d = branch & zero;
      erroAcesso_d   = ilegal;
    end
  end

  // MEM/WB register; reset clears every output regardless of stall/flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      validoWb_q     <= 1'b0;
      resultadoWb_q  <= '0;
      dadoLido_q     <= '0;
      regDestWb_q    <= '0;
      regWriteWb_q   <= 1'b0;
      memToRegWb_q   <= 1'b0;
      desvioTomado_q <= 1'b0;
      erroAcesso_q   <= 1'b0;
    end else begin
      validoWb_q     <= validoWb_d;
      resultadoWb_q  <= resultadoWb_d;
      dadoLido_q     <= dadoLido_d;
      regDestWb_q    <= regDestWb_d;
      regWriteWb_q   <= regWriteWb_d;
      memToRegWb_q   <= memToRegWb_d;
      desvioTomado_q <= desvioTomado_d;
      erroAcesso_q   <= erroAcesso_d;
    end
  end

  // Data RAM write port. Contents survive reset; reset only blocks the write
  // through aceita.
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem[endereco] <= dado_escrita;
    end
  end

  assign valido_wb     = validoWb_q;
  assign resultado_wb  = resultadoWb_q;
  assign dado_lido     = dadoLido_q;
  assign reg_dest_wb   = regDestWb_q;
  assign reg_write_wb  = regWriteWb_q;
  assign mem_to_reg_wb = memToRegWb_q;
  assign desvio_tomado = desvioTomado_q;
  assign erro_acesso   = erroAcesso_q;

endmodule

// File: doc/estagio_mem.md
# estagio_mem

Memory-access stage and EX/MEM pipeline register of the processor. It sits directly downstream of the EX-stage ALU and captures `resultado` and `zero` with the EX control bits. It performs a word-aligned load or store on an internal synchronous data RAM. It presents a registered MEM/WB bundle, including the branch-taken decision, to writeback and fetch.

## Interface
- `DATA_W`, 32, data and ALU result width.
- `ADDR_W`, 8, word-address width; RAM depth is 2^ADDR_W words.
- `REG_W`, 5, destination register index width.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `valido_ex`  in  1  EX presents a valid instruction this cycle.
- `resultado`  in  DATA_W  ALU result; byte address for loads/stores, value otherwise.
- `zero`  in  1  ALU zero flag.
- `dado_escrita`  in  DATA_W  store data.
- `mem_read`, `mem_write`, `reg_write`, `mem_to_reg`, `branch`  in  1 each  EX control bits.
- `reg_dest`  in  REG_W  destination register.
- `stall`  in  1  hold this stage; upstream holds its outputs.
- `flush`  in  1  squash the instruction entering this cycle.
- `valido_wb`  out  1  MEM/WB bundle valid.
- `resultado_wb`  out  DATA_W  registered `resultado`.
- `dado_lido`  out  DATA_W  load data.
- `reg_dest_wb`  out  REG_W.
- `reg_write_wb`, `mem_to_reg_wb`  out  1 each.
- `desvio_tomado`  out  1  `branch & zero` of a valid instruction.
- `erro_acesso`  out  1  illegal memory access flagged for this instruction.

## Operation
- Accept condition: `aceita = valido_ex & ~stall & ~flush & ~reset`.
- Word address is `resultado[ADDR_W+1:2]`. Higher bits are ignored, so the address wraps modulo the RAM depth.
- An access is illegal when `(mem_read | mem_write)` is set and either `resultado[1:0] != 0` or `mem_read & mem_write`. An illegal access is suppressed entirely: no RAM write, `dado_lido` = 0. The instruction still advances with `erro_acesso` = 1 and `reg_write_wb` = 0.
- Store: on a legal access with `aceita & mem_write`, `RAM[addr] <= dado_escrita` at the clock edge.
- Load: on a legal access with `aceita & mem_read`, `dado_lido` takes `RAM[addr]` at the same edge. The RAM is read synchronously and returns the old contents.
- Non-memory instruction: `dado_lido` = 0.
- `desvio_tomado` is registered as `branch & zero` for the accepted instruction.
- Stall (without flush): every output register holds its value and the RAM is not written.
- Flush has priority over stall. The next edge loads a bubble: `valido_wb`, `reg_write_wb`, `mem_to_reg_wb`, `desvio_tomado` and `erro_acesso` all go to 0. Data outputs are don't-care, driven 0. No RAM write occurs.
- Not stalled and `valido_ex` = 0: a bubble is loaded, same as flush.
- RAM contents are not cleared by reset.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N has its outputs valid from just after edge N until edge N+1, or longer while stalled.
- Store then load to the same address in consecutive accepted cycles: the load returns the newly stored data. The write commits at edge N and the read samples at edge N+1.
- Reset asserted at edge N: all outputs are 0 after edge N and any write presented in that cycle is suppressed. This applies even mid-stall or with `flush` asserted.
- Reset values: `valido_wb`, `resultado_wb`, `dado_lido`, `reg_dest_wb`, `reg_write_wb`, `mem_to_reg_wb`, `desvio_tomado` and `erro_acesso` are all 0.
- `stall` and `flush` are sampled only at the rising edge; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then a store of 0xDEADBEEF at `resultado` = 0x10, then a load from 0x10 on the next cycle -> the cycle after the load edge shows `dado_lido` = 0xDEADBEEF, `mem_to_reg_wb` = 1, `valido_wb` = 1.
- ALU op with `resultado` = 0x1234, `reg_write` = 1, `reg_dest` = 7 -> next cycle `resultado_wb` = 0x1234, `reg_dest_wb` = 7, `dado_lido` = 0.
- Load from 0x13 (misaligned), then load from 0x400 with `ADDR_W` = 8 -> the first gives `erro_acesso` = 1, `reg_write_wb` = 0. The second wraps to word 0 and returns RAM[0].
- `branch` = 1, `zero` = 1, with `stall` held for 3 cycles and then `flush` -> `desvio_tomado` = 1 is held for 3 cycles. After the flush edge, `valido_wb` = 0 and `desvio_tomado` = 0.
- Store to 0x20 with `stall` = 1, then `flush` = 1 with a store to 0x24 -> RAM[0x20] and RAM[0x24] are unchanged, as verified by later loads.
- Reset asserted in the same cycle as a store to 0x08 -> all outputs are 0 and a subsequent load from 0x08 returns the prior contents.
